esm_dwell_sequencer: RTL and testbench
======================================

Name: esm_dwell_sequencer

Overview:
Executes the dwell program that configures the ESM receiver's tuning schedule. Steps through a local instruction memory, looks up each instruction's dwell entry, and issues a fast-lock tune request to the AD9361 control logic. After tune completion it holds a timed dwell window for downstream channelizer/pulse detector gating. Sits between the dwell-program/entry config decode and the AD9361 control and ESM datapath enables, in the Adc_clk domain.

Parameters:
NUM_INSTRUCTIONS, 32, instruction memory depth; index width clog2(NUM_INSTRUCTIONS)
NUM_ENTRIES, 32, dwell entry table depth; index width clog2(NUM_ENTRIES)
DURATION_WIDTH, 32, dwell duration counter width in Clk cycles
TUNE_TIMEOUT, 1024, max cycles to wait for Tune_done

Ports:
Clk  in  1  sequencer clock (Adc_clk domain)
Rstn  in  1  asynchronous active-low reset
Program_enable  in  1  level; rising edge starts the program at instruction 0; low aborts
Global_counter_init  in  32  loaded on program start
Instr_wr_valid  in  1  instruction write strobe
Instr_wr_index  in  clog2(NUM_INSTRUCTIONS)  write address
Instr_wr_data  in  32  packed: [0] valid, [1] gc_check, [2] gc_dec, [15:8] repeat_count, [23:16] entry_index, [31:24] next_index
Instr_wr_error  out  1  pulse: write dropped (not idle)
Entry_rd_index  out  clog2(NUM_ENTRIES)  entry table address
Entry_rd_duration  in  DURATION_WIDTH  duration, valid 1 cycle after address
Entry_rd_profile  in  8  fast-lock profile, same timing
Tune_req  out  1  single-cycle tune request
Tune_profile  out  8  held stable from Tune_req until Tune_done/timeout
Tune_done  in  1  tune complete pulse
Tune_error  out  1  pulse on timeout
Dwell_active  out  1  high for dwell window
Dwell_entry_index  out  clog2(NUM_ENTRIES)  entry of current dwell, valid while Dwell_active
Dwell_start  out  1  pulse, first active cycle
Dwell_done  out  1  pulse, cycle after last active cycle
Program_running  out  1  high when state not S_IDLE/S_DONE

Behaviour:
- Reset: state S_IDLE; all outputs 0; counters 0. Instruction memory is not reset; contents undefined until written.
- Instruction writes are accepted only in S_IDLE/S_DONE. Otherwise they are dropped and Instr_wr_error pulses for 1 cycle.
- S_IDLE: on Program_enable rising edge:
  - load global counter, pc=0, go to S_FETCH_INST.
  - This also applies from S_DONE, which requires Program_enable to fall and rise again.
- S_FETCH_INST: read instr[pc] (combinational register-file read):
  - invalid -> S_DONE.
  - gc_check=1 and global counter==0 -> S_DONE.
  - otherwise latch the instruction, rep_cnt=repeat_count, drive Entry_rd_index=entry_index, go to S_FETCH_ENTRY.
- S_FETCH_ENTRY (1 cycle): latch duration and profile (duration 0 is treated as 1), go to S_TUNE.
- S_TUNE: Tune_req=1 for 1 cycle, go to S_WAIT_TUNE.
- S_WAIT_TUNE:
  - Tune_done -> S_DWELL on the next cycle.
  - After TUNE_TIMEOUT cycles without Tune_done: Tune_error pulse, skip the dwell, go to S_NEXT (counts as a completed repetition).
- S_DWELL:
  - Dwell_active high for exactly duration cycles; Dwell_start on the first cycle.
  - Dwell_done on the cycle after the last active cycle, concurrent with entering S_NEXT.
- S_NEXT:
  - rep_cnt!=0 -> rep_cnt-1, go to S_TUNE. The entry is not refetched, so instruction i runs repeat_count+1 dwells.
  - else: if gc_dec=1 and counter>0, decrement (saturate at 0); pc=next_index; go to S_FETCH_INST.
  - next_index >= NUM_INSTRUCTIONS -> S_DONE.
- Loops (next_index pointing backward) are legal; termination relies on gc_check.
- Program_enable low in any state: next cycle goes to S_IDLE, Dwell_active=0, no Dwell_done, no Tune_req.
- Tune_done outside S_WAIT_TUNE is ignored.

Optional Feature:
ESM_DWELL_SEQ_DELAYED_START_EN:
- Defined: adds ports Timestamp (in 64) and Delayed_start_enable (in 1), Delayed_start_time (in 64), plus state S_WAIT_START between S_IDLE and S_FETCH_INST. The sequencer waits until Timestamp >= Delayed_start_time when enabled. Program_running is high during the wait.
- Undefined: ports absent; start is immediate.

Decomposition:
- esm_pkg gains:
  - esm_dwell_seq_state_t enum.
  - esm_dwell_instruction_t packed layout (reuse existing).
  - esm_num_dwell_instructions / esm_num_dwell_entries constants as parameter defaults.
- One sub-module: esm_dwell_instruction_mem (write port plus async read).

Test Plan:
- Load 3 linear instructions (entries 0,1,2; repeat 0; durations 100,200,50), then next_index=NUM_INSTRUCTIONS-1 with invalid terminator, Tune_done 5 cycles after each request -> 3 Tune_req, Dwell_active widths 100/200/50, then S_DONE.
- Instruction repeat_count=3, duration 10 -> 4 Tune_req, 4 dwells of 10 cycles, single entry fetch.
- Loop instr0->instr0 with gc_check=gc_dec=1, Global_counter_init=5 -> exactly 5 dwells, then done.
- Tune_done withheld -> Tune_error after 1024 cycles, no Dwell_active, sequencer advances.
- Drop Program_enable mid-dwell at cycle 40 of 100 -> Dwell_active low next cycle, no Dwell_done, idle. A write during the run -> Instr_wr_error pulse, memory unchanged.
- With ESM_DWELL_SEQ_DELAYED_START_EN, Delayed_start_time=Timestamp+500 -> first Tune_req no earlier than 500 cycles after enable.

Source files
------------

// File: rtl/esm_pkg.sv
// Shared ESM types: dwell sequencer states, packed dwell instruction layout and table depths.
package esm_pkg;

  localparam int esm_num_dwell_instructions = 32;
  localparam int esm_num_dwell_entries      = 32;

  typedef struct packed {
    logic [7:0] next_index;
    logic [7:0] entry_index;
    logic [7:0] repeat_count;
    logic [4:0] rsvd;
    logic       gc_dec;
    logic       gc_check;
    logic       valid;
  } esm_dwell_instruction_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_START,
    S_FETCH_INST,
    S_FETCH_ENTRY,
    S_TUNE,
    S_WAIT_TUNE,
    S_DWELL,
    S_NEXT,
    S_DONE
  } esm_dwell_seq_state_t;

endpackage

// File: rtl/esm_dwell_instruction_mem.sv
// Dwell program store: one synchronous write port, combinational read port, no reset.
module esm_dwell_instruction_mem
  import esm_pkg::*;
#(
  parameter int NUM_INSTRUCTIONS = esm_num_dwell_instructions,
  localparam int IW = $clog2(NUM_INSTRUCTIONS)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [IW-1:0]          wr_index,
  input  logic [31:0]            wr_data,
  input  logic [IW-1:0]          rd_index,
  output esm_dwell_instruction_t rd_data
);

  logic [31:0] mem [NUM_INSTRUCTIONS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_index] <= wr_data;
  end

  assign rd_data = esm_dwell_instruction_t'(mem[rd_index]);

endmodule

// File: rtl/esm_dwell_sequencer.sv
// ESM dwell program sequencer: fetch instruction/entry, fast-lock tune, timed dwell window.
// Optional ESM_DWELL_SEQ_DELAYED_START_EN holds the program start until a timestamp is reached.
module esm_dwell_sequencer
  import esm_pkg::*;
#(
  parameter int NUM_INSTRUCTIONS = esm_num_dwell_instructions,
  parameter int NUM_ENTRIES      = esm_num_dwell_entries,
  parameter int DURATION_WIDTH   = 32,
  parameter int TUNE_TIMEOUT     = 1024,
  localparam int IW = $clog2(NUM_INSTRUCTIONS),
  localparam int EW = $clog2(NUM_ENTRIES)
) (
  input  logic                      Clk,
  input  logic                      Rstn,
`ifdef ESM_DWELL_SEQ_DELAYED_START_EN
  input  logic [63:0]               Timestamp,
  input  logic                      Delayed_start_enable,
  input  logic [63:0]               Delayed_start_time,
`endif
  input  logic                      Program_enable,
  input  logic [31:0]               Global_counter_init,
  input  logic                      Instr_wr_valid,
  input  logic [IW-1:0]             Instr_wr_index,
  input  logic [31:0]               Instr_wr_data,
  output logic                      Instr_wr_error,
  output logic [EW-1:0]             Entry_rd_index,
  input  logic [DURATION_WIDTH-1:0] Entry_rd_duration,
  input  logic [7:0]                Entry_rd_profile,
  output logic                      Tune_req,
  output logic [7:0]                Tune_profile,
  input  logic                      Tune_done,
  output logic                      Tune_error,
  output logic                      Dwell_active,
  output logic [EW-1:0]             Dwell_entry_index,
  output logic                      Dwell_start,
  output logic                      Dwell_done,
  output logic                      Program_running
);

  localparam int TW = $clog2(TUNE_TIMEOUT + 1);

  esm_dwell_seq_state_t   state;
  esm_dwell_instruction_t rd_ins;
  logic [IW-1:0]             pc;
  logic [31:0]               gc;
  logic [7:0]                rep_cnt;
  logic [7:0]                next_idx;
  logic                      gc_dec;
  logic [EW-1:0]             entry;
  logic [DURATION_WIDTH-1:0] dur, dcnt;
  logic [TW-1:0]             tcnt;
  logic                      pe_q;
  logic                      start;
  logic                      wr_ok;

  assign start           = Program_enable & ~pe_q;
  assign wr_ok           = (state == S_IDLE) || (state == S_DONE);
  assign Program_running = ~wr_ok;
  assign Dwell_entry_index = entry;
  // Address goes out during the fetch cycle so the table's 1-cycle data lands in S_FETCH_ENTRY.
  assign Entry_rd_index  = (state == S_FETCH_INST) ? EW'(rd_ins.entry_index) : entry;

  esm_dwell_instruction_mem #(.NUM_INSTRUCTIONS(NUM_INSTRUCTIONS)) u_imem (
    .clk      (Clk),
    .wr_en    (Instr_wr_valid & wr_ok),
    .wr_index (Instr_wr_index),
    .wr_data  (Instr_wr_data),
    .rd_index (pc),
    .rd_data  (rd_ins)
  );

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state          <= S_IDLE;
      pe_q           <= 1'b0;
      pc             <= '0;
      gc             <= '0;
      rep_cnt        <= '0;
      next_idx       <= '0;
      gc_dec         <= 1'b0;
      entry          <= '0;
      dur            <= '0;
      dcnt           <= '0;
      tcnt           <= '0;
      Instr_wr_error <= 1'b0;
      Tune_req       <= 1'b0;
      Tune_profile   <= '0;
      Tune_error     <= 1'b0;
      Dwell_active   <= 1'b0;
      Dwell_start    <= 1'b0;
      Dwell_done     <= 1'b0;
    end else begin
      pe_q           <= Program_enable;
      Instr_wr_error <= Instr_wr_valid & ~wr_ok;
      Tune_req       <= 1'b0;
      Tune_error     <= 1'b0;
      Dwell_start    <= 1'b0;
      Dwell_done     <= 1'b0;
      if (!Program_enable) begin
        state        <= S_IDLE;
        Dwell_active <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: if (start) begin
            gc <= Global_counter_init;
            pc <= '0;
`ifdef ESM_DWELL_SEQ_DELAYED_START_EN
            state <= Delayed_start_enable ? S_WAIT_START : S_FETCH_INST;
`else
            state <= S_FETCH_INST;
`endif
          end
`ifdef ESM_DWELL_SEQ_DELAYED_START_EN
          S_WAIT_START: if (Timestamp >= Delayed_start_time) state <= S_FETCH_INST;
`endif
          S_FETCH_INST: begin
            if (!rd_ins.valid || (rd_ins.gc_check && gc == '0)) state <= S_DONE;
            else begin
              rep_cnt  <= rd_ins.repeat_count;
              entry    <= EW'(rd_ins.entry_index);
              next_idx <= rd_ins.next_index;
              gc_dec   <= rd_ins.gc_dec;
              state    <= S_FETCH_ENTRY;
            end
          end
          S_FETCH_ENTRY: begin
            dur          <= (Entry_rd_duration == '0) ? DURATION_WIDTH'(1) : Entry_rd_duration;
            Tune_profile <= Entry_rd_profile;
            Tune_req     <= 1'b1;
            state        <= S_TUNE;
          end
          S_TUNE: begin
            tcnt  <= '0;
            state <= S_WAIT_TUNE;
          end
          S_WAIT_TUNE: begin
            if (Tune_done) begin
              dcnt         <= '0;
              Dwell_active <= 1'b1;
              Dwell_start  <= 1'b1;
              state        <= S_DWELL;
            end else if (tcnt == TW'(TUNE_TIMEOUT - 1)) begin
              Tune_error <= 1'b1;
              state      <= S_NEXT;
            end else tcnt <= tcnt + TW'(1);
          end
          S_DWELL: begin
            if (dcnt == dur - DURATION_WIDTH'(1)) begin
              Dwell_active <= 1'b0;
              Dwell_done   <= 1'b1;
              state        <= S_NEXT;
            end else dcnt <= dcnt + DURATION_WIDTH'(1);
          end
          S_NEXT: begin
            // Repeats reuse the latched entry; only the tune/dwell pair is replayed.
            if (rep_cnt != 8'd0) begin
              rep_cnt  <= rep_cnt - 8'd1;
              Tune_req <= 1'b1;
              state    <= S_TUNE;
            end else begin
              if (gc_dec && gc != '0) gc <= gc - 32'd1;
              if ({24'd0, next_idx} >= 32'(NUM_INSTRUCTIONS)) state <= S_DONE;
              else begin
                pc    <= IW'(next_idx);
                state <= S_FETCH_INST;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_esm_dwell_sequencer.sv
// Randomized self-checking bench for esm_dwell_sequencer against a program-level reference model.
module tb_esm_dwell_sequencer;
  localparam int NI = 32;
  localparam int NE = 32;

  typedef struct { int err; int entry; int dur; int prof; } item_t;

  logic        Clk = 0, Rstn = 0;
  logic        Program_enable = 0;
  logic [31:0] Global_counter_init = 0;
  logic        Instr_wr_valid = 0;
  logic [4:0]  Instr_wr_index = 0;
  logic [31:0] Instr_wr_data = 0;
  logic        Instr_wr_error;
  logic [4:0]  Entry_rd_index;
  logic [31:0] Entry_rd_duration;
  logic [7:0]  Entry_rd_profile;
  logic        Tune_req;
  logic [7:0]  Tune_profile;
  logic        Tune_done = 0;
  logic        Tune_error, Dwell_active, Dwell_start, Dwell_done, Program_running;
  logic [4:0]  Dwell_entry_index;
`ifdef ESM_DWELL_SEQ_DELAYED_START_EN
  logic [63:0] Timestamp = 0;
  logic        Delayed_start_enable = 0;
  logic [63:0] Delayed_start_time = 0;
  always @(posedge Clk) Timestamp <= Timestamp + 64'd1;
`endif

  esm_dwell_sequencer dut (
    .Clk(Clk), .Rstn(Rstn),
`ifdef ESM_DWELL_SEQ_DELAYED_START_EN
    .Timestamp(Timestamp), .Delayed_start_enable(Delayed_start_enable),
    .Delayed_start_time(Delayed_start_time),
`endif
    .Program_enable(Program_enable), .Global_counter_init(Global_counter_init),
    .Instr_wr_valid(Instr_wr_valid), .Instr_wr_index(Instr_wr_index),
    .Instr_wr_data(Instr_wr_data), .Instr_wr_error(Instr_wr_error),
    .Entry_rd_index(Entry_rd_index), .Entry_rd_duration(Entry_rd_duration),
    .Entry_rd_profile(Entry_rd_profile), .Tune_req(Tune_req), .Tune_profile(Tune_profile),
    .Tune_done(Tune_done), .Tune_error(Tune_error), .Dwell_active(Dwell_active),
    .Dwell_entry_index(Dwell_entry_index), .Dwell_start(Dwell_start),
    .Dwell_done(Dwell_done), .Program_running(Program_running)
  );

  always #5 Clk = ~Clk;

  int tests = 0, fails = 0;
  task automatic chk(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // entry table: data valid one cycle after address
  int unsigned dur_tab [NE];
  logic [7:0]  prof_tab [NE];
  always @(posedge Clk) begin
    Entry_rd_duration <= dur_tab[Entry_rd_index];
    Entry_rd_profile  <= prof_tab[Entry_rd_index];
  end

  logic [31:0] prog [NI];
  item_t expq[$];
  item_t obs[$];

  // tune responder + monitor
  int cyc = 0, td_cnt = 0, n_req = 0, n_done = 0, req_cyc = 0, dw_w = 0, cur_entry = 0;
  int first_req_cyc = 0, req_base = 0, withhold_n = 0, tune_delay = 1;
  logic [7:0] last_prof = 0;
  always @(negedge Clk) begin
    cyc++;
    Tune_done = 0;
    if (td_cnt > 0) begin
      td_cnt--;
      if (td_cnt == 0) begin
        Tune_done = 1;
        chk("prof_hold", Tune_profile, last_prof);
      end
    end
    if (Tune_req) begin
      if (n_req == req_base) first_req_cyc = cyc;
      n_req++;
      req_cyc = cyc;
      last_prof = Tune_profile;
      td_cnt = (n_req - req_base <= withhold_n) ? 0 : tune_delay;
    end
    if (Dwell_start) begin
      dw_w = 0;
      cur_entry = Dwell_entry_index;
      chk("tune_lat", cyc - req_cyc, tune_delay + 1);
    end
    if (Dwell_active) dw_w++;
    if (Dwell_done) begin
      n_done++;
      obs.push_back('{0, cur_entry, dw_w, int'(last_prof)});
    end
    if (Tune_error) begin
      chk("tout_lat", (cyc - req_cyc >= 1024) && (cyc - req_cyc <= 1025), 1);
      obs.push_back('{1, 0, 0, int'(last_prof)});
    end
  end

  function automatic logic [31:0] mk(input bit v, input bit c, input bit d,
                                     input int rep, input int ent, input int nxt);
    return {nxt[7:0], ent[7:0], rep[7:0], 5'd0, d, c, v};
  endfunction

  // reference: walk the program as the rules describe, listing each tune attempt's outcome
  task automatic model(input logic [31:0] gci, input int wh);
    int pc, nreq, steps, e;
    logic [31:0] gc, w;
    pc = 0; nreq = 0; steps = 0; gc = gci;
    expq.delete();
    while (steps < 2000) begin
      w = prog[pc];
      steps++;
      if (!w[0] || (w[1] && gc == 0)) break;
      e = int'(w[23:16]) % NE;
      for (int r = 0; r <= int'(w[15:8]); r++) begin
        nreq++;
        if (nreq <= wh) expq.push_back('{1, 0, 0, int'(prof_tab[e])});
        else expq.push_back('{0, e, (dur_tab[e] == 0) ? 1 : int'(dur_tab[e]), int'(prof_tab[e])});
      end
      if (w[2] && gc != 0) gc--;
      if (int'(w[31:24]) >= NI) break;
      pc = int'(w[31:24]);
    end
  endtask

  task automatic wr(input int idx, input logic [31:0] d, input bit exp_err);
    Instr_wr_valid = 1; Instr_wr_index = idx[4:0]; Instr_wr_data = d;
    @(negedge Clk);
    Instr_wr_valid = 0;
    chk("wr_err", Instr_wr_error, exp_err);
    if (!exp_err) prog[idx] = d;
  endtask

  int start_cyc = 0;
  task automatic run(input string tag, input logic [31:0] gci, input int dly, input int wh);
    int ob, g;
    model(gci, wh);
    tune_delay = dly; withhold_n = wh; req_base = n_req;
    ob = obs.size();
    Global_counter_init = gci;
    Program_enable = 1;
    start_cyc = cyc;
    @(negedge Clk);
    chk({tag, ":running"}, Program_running, 1);
    g = 0;
    while (Program_running && g < 20000) begin @(negedge Clk); g++; end
    chk({tag, ":finished"}, g < 20000, 1);
    chk({tag, ":n_items"}, obs.size() - ob, expq.size());
    for (int i = 0; i < expq.size() && ob + i < obs.size(); i++) begin
      chk({tag, ":err"},   obs[ob+i].err,   expq[i].err);
      chk({tag, ":entry"}, obs[ob+i].entry, expq[i].entry);
      chk({tag, ":dur"},   obs[ob+i].dur,   expq[i].dur);
      chk({tag, ":prof"},  obs[ob+i].prof,  expq[i].prof);
    end
    Program_enable = 0;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, nd, n;
    for (int i = 0; i < NE; i++) begin dur_tab[i] = 10; prof_tab[i] = 8'(i + 16); end
    repeat (2) @(negedge Clk);
    chk("rst_running", Program_running, 0);
    chk("rst_dwell", Dwell_active, 0);
    chk("rst_tune_req", Tune_req, 0);
    Rstn = 1;
    @(negedge Clk);
    chk("rst_tune_err", Tune_error, 0);
    chk("rst_wr_err", Instr_wr_error, 0);
    chk("rst_profile", Tune_profile, 0);
    chk("rst_entry", Entry_rd_index, 0);
    chk("rst_dstart", Dwell_start | Dwell_done, 0);
    for (int i = 0; i < NI; i++) wr(i, 32'd0, 0);

    // linear three-instruction program
    dur_tab[0] = 100; dur_tab[1] = 200; dur_tab[2] = 50;
    wr(0, mk(1, 0, 0, 0, 0, 1), 0);
    wr(1, mk(1, 0, 0, 0, 1, 2), 0);
    wr(2, mk(1, 0, 0, 0, 2, NI - 1), 0);
    run("linear", 0, 5, 0);

    // repeat count and next_index past the end
    dur_tab[4] = 10;
    wr(0, mk(1, 0, 0, 3, 4, 200), 0);
    run("repeat", 0, 3, 0);

    // zero duration counts as one
    dur_tab[3] = 0;
    wr(0, mk(1, 0, 0, 0, 3, 255), 0);
    run("zero_dur", 0, 2, 0);

    // global counter bounded loop
    wr(0, mk(1, 1, 1, 0, 5, 0), 0);
    run("loop", 5, 4, 0);

    // first tune times out, sequencer advances to the next instruction
    dur_tab[7] = 3;
    wr(0, mk(1, 0, 0, 0, 6, 1), 0);
    wr(1, mk(1, 0, 0, 0, 7, NI - 1), 0);
    run("timeout", 0, 2, 1);

    // abort mid-dwell; write during run is rejected
    dur_tab[9] = 100; dur_tab[2] = 7;
    wr(3, mk(1, 0, 0, 0, 2, NI - 1), 0);
    wr(0, mk(1, 0, 0, 0, 9, NI - 1), 0);
    tune_delay = 5; withhold_n = 0; req_base = n_req;
    Program_enable = 1;
    g = 0;
    while (!Dwell_start && g < 2000) begin @(negedge Clk); g++; end
    chk("abort:dwell_seen", Dwell_start, 1);
    repeat (10) @(negedge Clk);
    wr(3, mk(0, 0, 0, 0, 0, 0), 1);
    repeat (28) @(negedge Clk);
    chk("abort:active_before", Dwell_active, 1);
    nd = n_done;
    Program_enable = 0;
    @(negedge Clk);
    chk("abort:active_after", Dwell_active, 0);
    chk("abort:running", Program_running, 0);
    repeat (3) @(negedge Clk);
    chk("abort:no_done", n_done, nd);
    wr(0, mk(1, 0, 0, 0, 9, 3), 0);
    dur_tab[9] = 4;
    run("mem_kept", 0, 1, 0);

    // randomized programs
    for (int k = 0; k < 6; k++) begin
      logic [31:0] gci;
      int mode;
      for (int i = 0; i < NE; i++) begin
        dur_tab[i] = $urandom_range(0, 30);
        prof_tab[i] = 8'($urandom);
      end
      n = $urandom_range(1, 4);
      mode = $urandom_range(0, 2);
      gci = $urandom;
      for (int i = 0; i < n; i++) begin
        int nxt;
        nxt = (i < n - 1) ? i + 1 : (mode == 0) ? NI - 1 : (mode == 1) ? $urandom_range(NI, 255) : 0;
        wr(i, mk(1, (mode == 2) && (i == 0), (mode == 2) && (i == n - 1),
                 $urandom_range(0, 2), $urandom_range(0, NE - 1), nxt), 0);
      end
      if (mode == 2) gci = $urandom_range(0, 3);
      run("rand", gci, $urandom_range(1, 8), (k == 2) ? 1 : 0);
    end

`ifdef ESM_DWELL_SEQ_DELAYED_START_EN
    dur_tab[0] = 5;
    wr(0, mk(1, 0, 0, 0, 0, NI - 1), 0);
    Delayed_start_enable = 1;
    Delayed_start_time = Timestamp + 64'd500;
    run("delayed", 0, 2, 0);
    chk("delayed:min_wait", (first_req_cyc - start_cyc) >= 500, 1);
    Delayed_start_enable = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
